// File: rtl/recip_trig_lut.sv
// recip_trig_lut: cosecant / secant / cotangent of an integer-degree angle as an IEEE-754 double.
// Latency: 3 cycles (S1 reduce, S2 look up, S3 sign/format), one result per cycle.
// Backpressure: in_ready = !(out_valid && !out_ready); a full stage holds on stall, bubbles still collapse.
// Ports: clk/reset_n (async assert, release synchronous to clk); in_valid/in_ready/func_sel/angle request side;
//        out_valid/out_ready/data_out/out_undef result side (out_undef marks singularities and illegal requests).
module recip_trig_lut #(
  parameter int ANGLE_W    = 9,
  parameter bit ENABLE_COT = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         func_sel,
  input  logic [ANGLE_W-1:0] angle,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        data_out,
  output logic               out_undef
);

  localparam real         PI      = 3.14159265358979323846;
  localparam logic [63:0] POS_INF = 64'h7FF0000000000000;
  localparam logic [63:0] QNAN    = 64'h7FF8000000000000;

  // ROM contents are evaluated at elaboration. Values that have an exact
  // double representation are pinned so rounding in sin/cos cannot leak in.
  function automatic logic [63:0] csc_bits(input int d);
    real x;
    x = real'(d) * PI / 180.0;
    if (d == 0)  return 64'h0;               // singular, never read as a value
    if (d == 30) return 64'h4000000000000000;
    if (d == 90) return 64'h3FF0000000000000;
    return $realtobits(1.0 / $sin(x));
  endfunction

  function automatic logic [63:0] cot_bits(input int d);
    real x;
    x = real'(d) * PI / 180.0;
    if (d == 0 || d == 90) return 64'h0;     // 0 is singular, 90 is exactly zero
    if (d == 45)           return 64'h3FF0000000000000;
    return $realtobits($cos(x) / $sin(x));
  endfunction

  logic [62:0] csc_rom [0:90];
  logic [62:0] cot_rom [0:90];

  for (genvar g = 0; g <= 90; g++) begin : g_rom
    localparam logic [63:0] CSC_W = csc_bits(g);
    localparam logic [63:0] COT_W = ENABLE_COT ? cot_bits(g) : 64'h0;
    assign csc_rom[g] = CSC_W[62:0];
    assign cot_rom[g] = COT_W[62:0];
  end

  // Pipeline control: the output stage frees when empty or draining, earlier
  // stages free when their successor frees or when they themselves are empty.
  logic stall, ld1, ld2, ld3, accept;
  logic s1_vld, s2_vld;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign ld3      = !stall;
  assign ld2      = ld3 || !s2_vld;
  assign ld1      = ld2 || !s1_vld;

  // S1: captured request and its range reduction
  logic [1:0]         s1_func;
  logic [ANGLE_W-1:0] s1_angle;
  logic [8:0]         a9, base;
  logic [6:0]         r7, ref7, s1_idx;
  logic               q_odd, s1_bad, s1_is_cot, s1_neg, s1_sing;

  always_comb begin
    a9     = s1_angle[8:0];
    s1_bad = (s1_angle >= ANGLE_W'(360)) || (s1_func == 2'd3) ||
             ((s1_func == 2'd2) && !ENABLE_COT);
    base   = 9'd0;
    q_odd  = 1'b0;
    if (a9 >= 9'd270) begin
      base  = 9'd270;
      q_odd = 1'b1;
    end else if (a9 >= 9'd180) begin
      base  = 9'd180;
    end else if (a9 >= 9'd90) begin
      base  = 9'd90;
      q_odd = 1'b1;
    end
    r7   = 7'(a9 - base);
    ref7 = q_odd ? 7'd90 - r7 : r7;

    s1_idx    = ref7;
    s1_is_cot = 1'b0;
    s1_neg    = 1'b0;
    s1_sing   = 1'b0;
    case (s1_func)
      2'd0: begin
        s1_neg  = (a9 > 9'd180);
        s1_sing = (ref7 == 7'd0);
      end
      2'd1: begin
        s1_idx  = 7'd90 - ref7;                 // sec(x) = csc(90 - x)
        s1_neg  = (a9 > 9'd90) && (a9 < 9'd270);
        s1_sing = (ref7 == 7'd90);
      end
      2'd2: begin
        s1_is_cot = 1'b1;
        s1_neg    = q_odd;
        s1_sing   = (ref7 == 7'd0);
      end
      default: ;
    endcase
    // Out-of-range angles reduce to garbage; keep the ROM index legal.
    if (s1_bad) s1_idx = 7'd0;
  end

  // S2: reduced request; table read and result formatting feed S3
  logic [6:0]  s2_idx;
  logic        s2_cot, s2_neg, s2_sing, s2_bad;
  logic [62:0] mag;
  logic [63:0] fmt_dat;
  logic        fmt_undef;

  always_comb begin
    mag       = s2_cot ? cot_rom[s2_idx] : csc_rom[s2_idx];
    fmt_dat   = {s2_neg, mag};
    fmt_undef = 1'b0;
    if (s2_bad) begin
      fmt_dat   = QNAN;
      fmt_undef = 1'b1;
    end else if (s2_sing) begin
      fmt_dat   = POS_INF;
      fmt_undef = 1'b1;
    end else if (mag == 63'd0) begin
      fmt_dat   = 64'h0;                        // never emit -0
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld    <= 1'b0;
      s1_func   <= 2'd0;
      s1_angle  <= '0;
      s2_vld    <= 1'b0;
      s2_idx    <= 7'd0;
      s2_cot    <= 1'b0;
      s2_neg    <= 1'b0;
      s2_sing   <= 1'b0;
      s2_bad    <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= 64'h0;
      out_undef <= 1'b0;
    end else begin
      if (ld1) begin
        s1_vld <= accept;
        if (accept) begin
          s1_func  <= func_sel;
          s1_angle <= angle;
        end
      end
      if (ld2) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_idx  <= s1_idx;
          s2_cot  <= s1_is_cot;
          s2_neg  <= s1_neg;
          s2_sing <= s1_sing;
          s2_bad  <= s1_bad;
        end
      end
      if (ld3) begin
        out_valid <= s2_vld;
        if (s2_vld) begin
          data_out  <= fmt_dat;
          out_undef <= fmt_undef;
        end
      end
    end
  end

endmodule

// File: tb/tb_recip_trig_lut.sv
// tb_recip_trig_lut: scoreboard bench for recip_trig_lut against a trig reference model.
// Stimulus process pushes expected results on acceptance; monitor compares the queue head every valid cycle.
// Random phase toggles in_valid/out_ready to exercise stalls, bubbles and simultaneous transfers.
module tb_recip_trig_lut;
  localparam int  ANGLE_W    = 9;
  localparam bit  ENABLE_COT = 1'b1;
  localparam real PI         = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         func_sel;
  logic [ANGLE_W-1:0] angle;
  logic               out_valid;
  logic               out_ready;
  logic [63:0]        data_out;
  logic               out_undef;

  recip_trig_lut #(.ANGLE_W(ANGLE_W), .ENABLE_COT(ENABLE_COT)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .func_sel(func_sel), .angle(angle),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .out_undef(out_undef)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] bits;     // exact expected encoding
    logic [63:0] vbits;    // reference value when compared with tolerance
    logic        undef;
    logic        exact;
    logic        chk_lat;
    logic [1:0]  func;
    logic [9:0]  ang;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  localparam int ND = 9;
  int          dir_f [ND] = '{0, 1, 1, 2, 2, 2, 1, 0, 3};
  int          dir_a [ND] = '{210, 60, 120, 45, 135, 270, 270, 400, 30};
  logic [63:0] dir_b [ND] = '{64'hC000000000000000, 64'h4000000000000000, 64'hC000000000000000,
                              64'h3FF0000000000000, 64'hBFF0000000000000, 64'h0000000000000000,
                              64'h7FF0000000000000, 64'h7FF8000000000000, 64'h7FF8000000000000};
  int          bp_f [4] = '{0, 1, 2, 0};
  int          bp_a [4] = '{30, 60, 45, 90};
  logic [63:0] bp_b [4] = '{64'h4000000000000000, 64'h4000000000000000,
                            64'h3FF0000000000000, 64'h3FF0000000000000};

  // Reference: evaluate the function directly on the full angle.
  function automatic exp_t model(input int f, input int a);
    exp_t e;
    real  x, v;
    e      = '0;
    e.func = 2'(f);
    e.ang  = 10'(a);
    x      = real'(a) * PI / 180.0;
    if (a >= 360 || f == 3 || (f == 2 && !ENABLE_COT)) begin
      e.bits = 64'h7FF8000000000000; e.undef = 1'b1; e.exact = 1'b1;
    end else if ((f != 1 && (a % 180) == 0) || (f == 1 && (a % 180) == 90)) begin
      e.bits = 64'h7FF0000000000000; e.undef = 1'b1; e.exact = 1'b1;
    end else begin
      case (f)
        0:       v = 1.0 / $sin(x);
        1:       v = 1.0 / $cos(x);
        default: v = $cos(x) / $sin(x);
      endcase
      e.vbits = $realtobits(v);
    end
    return e;
  endfunction

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_res(input exp_t e);
    bit  ok;
    real w, d, diff, aw;
    n_vec++;
    if (e.exact) begin
      ok = (data_out === e.bits) && (out_undef === e.undef);
    end else begin
      w    = $bitstoreal(e.vbits);
      d    = $bitstoreal(data_out);
      diff = (d > w) ? d - w : w - d;
      aw   = (w < 0.0) ? -w : w;
      if (aw < 1e-9) ok = (data_out === 64'h0) && (out_undef === 1'b0);
      else           ok = (out_undef === 1'b0) && (diff <= 1e-9 * aw);
    end
    if (!ok) begin
      n_err++;
      $display("FAIL result func=%0d angle=%0d: got %h undef=%0b, want %h undef=%0b",
               e.func, e.ang, data_out, out_undef, e.exact ? e.bits : e.vbits, e.undef);
    end
  endtask

  // Monitor: the queue head must be on the output every valid cycle (so a
  // stalled output is also checked for stability); pop on transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && out_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %h, want no output", data_out);
        end else begin
          check_res(sb[0]);
          if (out_ready) begin
            e = sb.pop_front();
            if (e.chk_lat) check_eq("latency", 64'(cyc - e.acc_cyc), 64'd3);
          end
        end
      end
    end
  end

  // One cycle of stimulus; pushes the expectation when the request is accepted.
  task automatic step(input bit v, input int f, input int a, input bit ordy, input bit lat,
                      input bit fbits, input logic [63:0] fb, output bit acc, output bit ov);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    func_sel  = 2'(f);
    angle     = ANGLE_W'(a);
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    ov  = out_valid;
    if (acc) begin
      e = model(f, a);
      if (fbits) begin
        e.bits  = fb;
        e.exact = 1'b1;
      end
      e.acc_cyc = cyc;
      e.chk_lat = lat;
      sb.push_back(e);
    end
  endtask

  task automatic send(input int f, input int a, input bit lat, input bit fbits, input logic [63:0] fb);
    bit acc, ov;
    int n;
    n = 0;
    do begin
      step(1'b1, f, a, 1'b1, lat, fbits, fb, acc, ov);
      n++;
    end while (!acc && n < 50);
    if (!acc) check_eq("send_accept", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    bit acc, ov;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 64'h0, acc, ov);
      n++;
    end
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    bit acc, ov;
    int nacc, guard, f, a;
    logic v, ordy;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    func_sel  = 2'd0;
    angle     = '0;
    out_ready = 1'b1;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_data_out",  data_out,       64'd0);
    check_eq("rst_out_undef", 64'(out_undef), 64'd0);
    check_eq("rst_in_ready",  64'(in_ready),  64'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // csc sweep, back-to-back, latency checked on every result
    for (int i = 0; i <= 90; i++)
      send(0, i, 1'b1, (i == 30 || i == 90), (i == 30) ? 64'h4000000000000000 : 64'h3FF0000000000000);

    for (int i = 0; i < ND; i++)
      send(dir_f[i], dir_a[i], 1'b1, 1'b1, dir_b[i]);
    drain();

    // Backpressure: 4 requests against a held-off consumer
    nacc = 0;
    for (int c = 0; c < 6; c++) begin
      step(nacc < 4, bp_f[nacc < 4 ? nacc : 3], bp_a[nacc < 4 ? nacc : 3], 1'b0, 1'b0, 1'b1,
           bp_b[nacc < 4 ? nacc : 3], acc, ov);
      if (acc) nacc++;
    end
    check_eq("bp_accepted", 64'(nacc), 64'd3);
    check_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
    step(nacc == 3, bp_f[3], bp_a[3], 1'b1, 1'b0, 1'b1, bp_b[3], acc, ov);
    check_eq("bp_fourth_accept", 64'(acc), 64'd1);
    check_eq("bp_drain_valid0", 64'(ov), 64'd1);
    for (int c = 1; c < 4; c++) begin
      step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 64'h0, acc, ov);
      check_eq("bp_drain_no_gap", 64'(ov), 64'd1);
    end
    drain();

    // Random stream with random input/output duty
    nacc  = 0;
    guard = 0;
    while (nacc < 200 && guard < 5000) begin
      f    = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
      a    = ($urandom_range(0, 15) == 0) ? int'($urandom_range(360, 511)) : int'($urandom_range(0, 359));
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      step(v, f, a, ordy, 1'b0, 1'b0, 64'h0, acc, ov);
      if (acc) nacc++;
      guard++;
    end
    check_eq("random_accepted", 64'(nacc), 64'd200);
    drain();

    // Reset with two requests in flight, the older one stalled on the output
    send(0, 30, 1'b0, 1'b1, 64'h4000000000000000);
    send(1, 60, 1'b0, 1'b1, 64'h4000000000000000);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_data_out",  data_out,       64'd0);
    check_eq("midrst_out_undef", 64'(out_undef), 64'd0);
    check_eq("midrst_in_ready",  64'(in_ready),  64'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send(0, 30, 1'b1, 1'b1, 64'h4000000000000000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
